// File: rtl/cache_types.sv
// ============================================================================
// Module      : cache_types (package)
// Description : Shared way codes, controller state encoding and way helpers
//               for the 4-way, 16-set write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types;

  localparam int c_sets  = 16;
  localparam int c_ways  = 4;
  localparam int c_set_w = $clog2(c_sets);

  typedef enum logic [1:0] {
    Way_A = 2'd0,
    Way_B = 2'd1,
    Way_C = 2'd2,
    Way_D = 2'd3
  } way_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_STALL     = 3'd4
  } ctrl_state_t;

  // Lowest set bit wins, so an illegal multi-hit still resolves deterministically.
  function automatic logic [1:0] onehot_to_way(input logic [c_ways-1:0] oh);
    logic [1:0] w;
    w = 2'd0;
    for (int i = c_ways - 1; i >= 0; i--) begin
      if (oh[i]) w = 2'(i);
    end
    return w;
  endfunction

  function automatic logic [c_ways-1:0] way_to_onehot(input logic [1:0] w);
    return c_ways'(1) << w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_victim_sel.sv
// ============================================================================
// Module      : cache_victim_sel
// Description : Combinational replacement-way choice. With
//               CACHE_INVALID_FIRST_EN defined an invalid way is preferred.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_victim_sel
  import cache_types::*;
(
  input  logic [c_ways-1:0] way_valid,
  input  logic [1:0]        plru_way_replace,
  output logic [1:0]        victim
);

`ifdef CACHE_INVALID_FIRST_EN
  always_comb begin
    victim = plru_way_replace;
    for (int i = c_ways - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim = 2'(i);
    end
  end
`else
  logic w_unused_valid;

  assign w_unused_valid = ^way_valid;
  assign victim         = plru_way_replace;
`endif

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// Module      : cache_ctrl
// Description : Sequencing FSM for the 4-way write-back data cache: compare,
//               writeback, allocate and re-read. Option: CACHE_INVALID_FIRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl
  import cache_types::*;
#(
  parameter int NUM_SETS = c_sets,
  parameter int NUM_WAYS = c_ways,
  localparam int SET_W   = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ufp_req,
  input  logic                ufp_write,
  input  logic [SET_W-1:0]    ufp_set,
  input  logic [NUM_WAYS-1:0] way_hit,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  input  logic [1:0]          plru_way_replace,
  output logic [1:0]          plru_way_visit,
  output logic                plru_update,
  output logic [SET_W-1:0]    plru_set,
  output logic                arr_en,
  output logic [NUM_WAYS-1:0] arr_we,
  output logic                arr_fill,
  output logic                arr_dirty_val,
  output logic [1:0]          victim_way,
  output logic                dfp_read,
  output logic                dfp_write,
  output logic                dfp_addr_sel,
  input  logic                dfp_resp,
  output logic                ufp_resp
);

  ctrl_state_t r_state;
  logic [1:0]  r_victim;
  logic [1:0]  w_victim;
  logic [1:0]  w_hit_way;
  logic        w_hit_any;
  logic        w_victim_dirty;

  cache_victim_sel u_victim_sel (
    .way_valid        (way_valid),
    .plru_way_replace (plru_way_replace),
    .victim           (w_victim)
  );

  assign w_hit_any      = |way_hit;
  assign w_hit_way      = onehot_to_way(way_hit);
  assign w_victim_dirty = way_valid[w_victim] & way_dirty[w_victim];
  assign plru_set       = ufp_set;
  assign victim_way     = r_victim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_victim <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ufp_req) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_hit_any) begin
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            r_state  <= w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (dfp_resp) r_state <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (dfp_resp) r_state <= S_STALL;
        end
        S_STALL: begin
          r_state <= S_COMPARE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The hit path must respond in the compare cycle, so decode is combinational on state.
  always_comb begin
    ufp_resp       = 1'b0;
    plru_update    = 1'b0;
    plru_way_visit = 2'd0;
    arr_en         = 1'b0;
    arr_we         = '0;
    arr_fill       = 1'b0;
    arr_dirty_val  = 1'b0;
    dfp_read       = 1'b0;
    dfp_write      = 1'b0;
    dfp_addr_sel   = 1'b0;
    case (r_state)
      S_IDLE: begin
        arr_en = ufp_req & rst;
      end
      S_COMPARE: begin
        if (w_hit_any) begin
          ufp_resp       = 1'b1;
          plru_update    = 1'b1;
          plru_way_visit = w_hit_way;
          if (ufp_write) begin
            arr_we        = way_to_onehot(w_hit_way);
            arr_dirty_val = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        dfp_write    = 1'b1;
        dfp_addr_sel = 1'b1;
      end
      S_ALLOCATE: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          arr_we   = way_to_onehot(r_victim);
          arr_fill = 1'b1;
        end
      end
      S_STALL: begin
        arr_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_COMPARE) |-> $onehot0(way_hit));

endmodule

`default_nettype wire
